// File: rtl/ex_operand_forward_if.sv
// ----------------------------------------------------------------------------
// ex_operand_forward_if
//   Bundles the EX operand-bypass signals between the pipeline (master) and
//   the forwarding unit (slave).
//
//   EX side    : ex_valid, ex_stall, ex_rs_idx, ex_rs_used, ex_rs_data
//   MEM side   : mem_valid, mem_rd_wen, mem_rd_idx, mem_rd_data,
//                mem_is_load, mem_load_done
//   WB side    : wb_valid, wb_rd_wen, wb_rd_idx, wb_rd_data
//   Results    : ex_src_fwd, ex_src_sel, fwd_load_use_stall, perf_lu_cnt
// ----------------------------------------------------------------------------
interface ex_operand_forward_if #(
  parameter int XLEN    = 64,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 32
);
  logic                    ex_valid;
  logic                    ex_stall;
  logic [NUM_SRC*5-1:0]    ex_rs_idx;
  logic [NUM_SRC-1:0]      ex_rs_used;
  logic [NUM_SRC*XLEN-1:0] ex_rs_data;

  logic                    mem_valid;
  logic                    mem_rd_wen;
  logic [4:0]              mem_rd_idx;
  logic [XLEN-1:0]         mem_rd_data;
  logic                    mem_is_load;
  logic                    mem_load_done;

  logic                    wb_valid;
  logic                    wb_rd_wen;
  logic [4:0]              wb_rd_idx;
  logic [XLEN-1:0]         wb_rd_data;

  logic [NUM_SRC*XLEN-1:0] ex_src_fwd;
  logic [NUM_SRC*2-1:0]    ex_src_sel;
  logic                    fwd_load_use_stall;
  logic [CNT_W-1:0]        perf_lu_cnt;

  // Pipeline side: provides stage state, consumes resolved operands.
  modport master (
    output ex_valid, ex_stall, ex_rs_idx, ex_rs_used, ex_rs_data,
    output mem_valid, mem_rd_wen, mem_rd_idx, mem_rd_data, mem_is_load, mem_load_done,
    output wb_valid, wb_rd_wen, wb_rd_idx, wb_rd_data,
    input  ex_src_fwd, ex_src_sel, fwd_load_use_stall, perf_lu_cnt
  );

  // Forwarding unit side.
  modport slave (
    input  ex_valid, ex_stall, ex_rs_idx, ex_rs_used, ex_rs_data,
    input  mem_valid, mem_rd_wen, mem_rd_idx, mem_rd_data, mem_is_load, mem_load_done,
    input  wb_valid, wb_rd_wen, wb_rd_idx, wb_rd_data,
    output ex_src_fwd, ex_src_sel, fwd_load_use_stall, perf_lu_cnt
  );
endinterface

// File: rtl/ex_operand_forward_unit.sv
// ----------------------------------------------------------------------------
// ex_operand_forward_unit
//   EX-stage operand bypass for NUM_SRC source operands. Each source index is
//   compared against the MEM, WB and a registered WB+1 shadow producer; the
//   youngest matching producer wins. Unresolved loads in MEM raise a load-use
//   stall. While EX is stalled the resolved operands are captured and replayed
//   so a producer that retires mid-stall is not lost.
//
//   Ports
//     clk  : clock
//     rst  : synchronous reset, active-high
//     bus  : ex_operand_forward_if.slave (EX/MEM/WB inputs, operand outputs)
//
//   ex_src_sel encoding per source: 0 RF, 1 MEM, 2 WB, 3 WB+1 shadow or HELD.
//   In HELD every source (used or not) replays the value captured on entry.
// ----------------------------------------------------------------------------
module ex_operand_forward_unit #(
  parameter int XLEN      = 64,
  parameter int NUM_SRC   = 2,
  parameter int RF_BYPASS = 0,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  ex_operand_forward_if.slave  bus
);

  typedef enum logic {
    ST_LIVE = 1'b0,
    ST_HELD = 1'b1
  } state_e;

  localparam logic [1:0] SEL_RF   = 2'd0;
  localparam logic [1:0] SEL_MEM  = 2'd1;
  localparam logic [1:0] SEL_WB   = 2'd2;
  localparam logic [1:0] SEL_HELD = 2'd3;   // also used for the WB+1 shadow

  // Registered state
  state_e                        state_q, state_d;
  logic [NUM_SRC-1:0][XLEN-1:0]  hold_q, hold_d;
  logic                          wb1_v_q, wb1_v_d;
  logic [4:0]                    wb1_idx_q, wb1_idx_d;
  logic [XLEN-1:0]               wb1_data_q, wb1_data_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;

  // Combinational match / mux results
  logic [NUM_SRC-1:0]            hit_mem, hit_wb, hit_wb1, lu;
  logic [NUM_SRC-1:0][XLEN-1:0]  mux_data;
  logic [NUM_SRC-1:0][1:0]       mux_sel;
  logic                          load_use_stall;
  logic                          wb_write;

  assign wb_write = bus.wb_valid && bus.wb_rd_wen && (bus.wb_rd_idx != 5'd0);

  // Per-source producer match and priority mux (MEM > WB > WB+1 > RF).
  // NOTE: every combinational output gets a default at the top of the block so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    hit_mem  = '0;
    hit_wb   = '0;
    hit_wb1  = '0;
    lu       = '0;
    mux_data = '0;
    mux_sel  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      hit_mem[i] = bus.ex_rs_used[i] && bus.mem_valid && bus.mem_rd_wen &&
                   (bus.mem_rd_idx == bus.ex_rs_idx[5*i +: 5]) &&
                   (bus.ex_rs_idx[5*i +: 5] != 5'd0);
      hit_wb[i]  = bus.ex_rs_used[i] && bus.wb_valid && bus.wb_rd_wen &&
                   (bus.wb_rd_idx == bus.ex_rs_idx[5*i +: 5]) &&
                   (bus.ex_rs_idx[5*i +: 5] != 5'd0);
      hit_wb1[i] = bus.ex_rs_used[i] && wb1_v_q &&
                   (wb1_idx_q == bus.ex_rs_idx[5*i +: 5]) &&
                   (bus.ex_rs_idx[5*i +: 5] != 5'd0);

      // Once operands are held, MEM activity is irrelevant, so a load in MEM
      // cannot re-raise the stall.
      lu[i] = hit_mem[i] && bus.mem_is_load && !bus.mem_load_done &&
              (state_q == ST_LIVE);

      if (hit_mem[i]) begin
        mux_data[i] = bus.mem_rd_data;
        mux_sel[i]  = SEL_MEM;
      end else if (hit_wb[i]) begin
        mux_data[i] = bus.wb_rd_data;
        mux_sel[i]  = SEL_WB;
      end else if (hit_wb1[i]) begin
        mux_data[i] = wb1_data_q;
        mux_sel[i]  = SEL_HELD;
      end else begin
        mux_data[i] = bus.ex_rs_data[XLEN*i +: XLEN];
        mux_sel[i]  = SEL_RF;
      end
    end
  end

  assign load_use_stall = bus.ex_valid && (|lu);

  // Operand outputs: held copy in HELD, live mux otherwise.
  always_comb begin
    bus.ex_src_fwd = '0;
    bus.ex_src_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (state_q == ST_HELD) begin
        bus.ex_src_fwd[XLEN*i +: XLEN] = hold_q[i];
        bus.ex_src_sel[2*i +: 2]       = SEL_HELD;
      end else begin
        bus.ex_src_fwd[XLEN*i +: XLEN] = mux_data[i];
        bus.ex_src_sel[2*i +: 2]       = mux_sel[i];
      end
    end
  end

  assign bus.fwd_load_use_stall = load_use_stall;
  assign bus.perf_lu_cnt        = cnt_q;

  // Next-state: LIVE/HELD sequencing, WB+1 shadow, stall counter.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    wb1_v_d    = (RF_BYPASS == 0) && wb_write;
    wb1_idx_d  = wb1_idx_q;
    wb1_data_d = wb1_data_q;
    cnt_d      = cnt_q;

    if (wb_write) begin
      wb1_idx_d  = bus.wb_rd_idx;
      wb1_data_d = bus.wb_rd_data;
    end

    unique case (state_q)
      ST_LIVE: begin
        // An unresolved load blocks capture; the capture happens on the first
        // stalled edge after the load data arrives.
        if (bus.ex_valid && bus.ex_stall && !load_use_stall) begin
          state_d = ST_HELD;
          hold_d  = mux_data;
        end
      end
      ST_HELD: begin
        if (!bus.ex_stall || !bus.ex_valid) begin
          state_d = ST_LIVE;
        end
      end
      default: state_d = ST_LIVE;
    endcase

    // Saturating: stays at all-ones instead of wrapping.
    if (load_use_stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_LIVE;
      hold_q  <= '0;
      wb1_v_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      wb1_v_q <= wb1_v_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: the shadow index/data are plain datapath registers with no reset;
  // they are only observed while wb1_v_q is set, and wb1_v_q is reset.
  always_ff @(posedge clk) begin
    wb1_idx_q  <= wb1_idx_d;
    wb1_data_q <= wb1_data_d;
  end

endmodule

// File: tb/tb_ex_operand_forward_unit.sv
// ----------------------------------------------------------------------------
// tb_ex_operand_forward_unit
//   Two instances share one stimulus stream:
//     dut0 : RF_BYPASS=0, CNT_W=32 (WB+1 shadow active)
//     dut1 : RF_BYPASS=1, CNT_W=2  (shadow disabled, tiny saturating counter)
//   A behavioural model predicts both; a scoreboard compares every cycle, and
//   directed scenarios pin literal values.
// ----------------------------------------------------------------------------
module tb_ex_operand_forward_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Stimulus
  logic         ex_valid, ex_stall;
  logic [9:0]   rs_idx;
  logic [1:0]   rs_used;
  logic [127:0] rs_data;
  logic         mem_valid, mem_rd_wen, mem_is_load, mem_load_done;
  logic [4:0]   mem_rd_idx;
  logic [63:0]  mem_rd_data;
  logic         wb_valid, wb_rd_wen;
  logic [4:0]   wb_rd_idx;
  logic [63:0]  wb_rd_data;

  ex_operand_forward_if #(.XLEN(64), .NUM_SRC(2), .CNT_W(32)) if0 ();
  ex_operand_forward_if #(.XLEN(64), .NUM_SRC(2), .CNT_W(2))  if1 ();

  assign if0.ex_valid = ex_valid;      assign if1.ex_valid = ex_valid;
  assign if0.ex_stall = ex_stall;      assign if1.ex_stall = ex_stall;
  assign if0.ex_rs_idx = rs_idx;       assign if1.ex_rs_idx = rs_idx;
  assign if0.ex_rs_used = rs_used;     assign if1.ex_rs_used = rs_used;
  assign if0.ex_rs_data = rs_data;     assign if1.ex_rs_data = rs_data;
  assign if0.mem_valid = mem_valid;    assign if1.mem_valid = mem_valid;
  assign if0.mem_rd_wen = mem_rd_wen;  assign if1.mem_rd_wen = mem_rd_wen;
  assign if0.mem_rd_idx = mem_rd_idx;  assign if1.mem_rd_idx = mem_rd_idx;
  assign if0.mem_rd_data = mem_rd_data; assign if1.mem_rd_data = mem_rd_data;
  assign if0.mem_is_load = mem_is_load; assign if1.mem_is_load = mem_is_load;
  assign if0.mem_load_done = mem_load_done; assign if1.mem_load_done = mem_load_done;
  assign if0.wb_valid = wb_valid;      assign if1.wb_valid = wb_valid;
  assign if0.wb_rd_wen = wb_rd_wen;    assign if1.wb_rd_wen = wb_rd_wen;
  assign if0.wb_rd_idx = wb_rd_idx;    assign if1.wb_rd_idx = wb_rd_idx;
  assign if0.wb_rd_data = wb_rd_data;  assign if1.wb_rd_data = wb_rd_data;

  ex_operand_forward_unit #(.XLEN(64), .NUM_SRC(2), .RF_BYPASS(0), .CNT_W(32)) dut0 (
    .clk (clk), .rst (rst), .bus (if0)
  );
  ex_operand_forward_unit #(.XLEN(64), .NUM_SRC(2), .RF_BYPASS(1), .CNT_W(2)) dut1 (
    .clk (clk), .rst (rst), .bus (if1)
  );

  // --------------------------------------------------------------------------
  // Check bookkeeping
  // --------------------------------------------------------------------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model: producers listed youngest first, first match wins.
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic        v;
    logic [4:0]  idx;
    logic [63:0] data;
  } prod_t;

  typedef struct packed {
    logic [1:0][63:0] fwd;
    logic [1:0][1:0]  sel;
    logic [1:0]       dc;     // operand value is don't-care (pending load)
    logic             stall;
  } exp_t;

  bit               m_held [2];
  logic [1:0][63:0] m_hold [2];
  bit               m_wb1_v [2];
  logic [4:0]       m_wb1_idx [2];
  logic [63:0]      m_wb1_data [2];
  longint unsigned  m_cnt [2];
  longint unsigned  cnt_max [2];

  initial begin
    cnt_max[0] = 64'd4294967295;
    cnt_max[1] = 64'd3;
    for (int c = 0; c < 2; c++) begin
      m_held[c] = 0; m_hold[c] = '0; m_wb1_v[c] = 0;
      m_wb1_idx[c] = '0; m_wb1_data[c] = '0; m_cnt[c] = 0;
    end
  end

  function automatic exp_t model_eval(input int c);
    exp_t        e;
    prod_t       p [3];
    logic [4:0]  r;
    bit          found;
    p[0] = '{v: mem_valid && mem_rd_wen, idx: mem_rd_idx, data: mem_rd_data};
    p[1] = '{v: wb_valid && wb_rd_wen,   idx: wb_rd_idx,  data: wb_rd_data};
    p[2] = '{v: m_wb1_v[c], idx: m_wb1_idx[c], data: m_wb1_data[c]};
    e = '0;
    for (int i = 0; i < 2; i++) begin
      r = rs_idx[5*i +: 5];
      e.fwd[i] = rs_data[64*i +: 64];
      e.sel[i] = 2'd0;
      found = 0;
      if (rs_used[i] && r != 5'd0) begin
        for (int k = 0; k < 3; k++) begin
          if (!found && p[k].v && p[k].idx == r) begin
            found    = 1;
            e.fwd[i] = p[k].data;
            e.sel[i] = 2'(k + 1);
            if (k == 0 && mem_is_load && !mem_load_done) e.dc[i] = 1'b1;
          end
        end
      end
      if (m_held[c]) begin
        e.fwd[i] = m_hold[c][i];
        e.sel[i] = 2'd3;
        e.dc[i]  = 1'b0;
      end
    end
    e.stall = ex_valid && (e.dc != 2'b00);
    return e;
  endfunction

  // Scoreboard: compare on the falling edge, advance the model on the rising
  // edge (inputs change only 1 time unit after the rising edge).
  initial begin : scoreboard
    exp_t         e [2];
    logic [127:0] a_fwd;
    logic [3:0]   a_sel;
    logic         a_stall;
    logic [63:0]  a_cnt;
    bit           wbw;
    @(posedge clk);
    forever begin
      @(negedge clk);
      for (int c = 0; c < 2; c++) begin
        e[c]    = model_eval(c);
        a_fwd   = (c == 0) ? if0.ex_src_fwd : if1.ex_src_fwd;
        a_sel   = (c == 0) ? if0.ex_src_sel : if1.ex_src_sel;
        a_stall = (c == 0) ? if0.fwd_load_use_stall : if1.fwd_load_use_stall;
        a_cnt   = (c == 0) ? 64'(if0.perf_lu_cnt) : 64'(if1.perf_lu_cnt);
        for (int i = 0; i < 2; i++) begin
          if (!e[c].dc[i]) check($sformatf("sb dut%0d fwd%0d", c, i), a_fwd[64*i +: 64], e[c].fwd[i]);
          check($sformatf("sb dut%0d sel%0d", c, i), 64'(a_sel[2*i +: 2]), 64'(e[c].sel[i]));
        end
        check($sformatf("sb dut%0d stall", c), 64'(a_stall), 64'(e[c].stall));
        check($sformatf("sb dut%0d cnt", c), a_cnt, m_cnt[c]);
      end
      @(posedge clk);
      for (int c = 0; c < 2; c++) begin
        if (rst) begin
          m_held[c] = 0; m_hold[c] = '0; m_wb1_v[c] = 0; m_cnt[c] = 0;
        end else begin
          wbw = wb_valid && wb_rd_wen && (wb_rd_idx != 5'd0);
          m_wb1_v[c] = (c == 0) && wbw;
          if (wbw) begin
            m_wb1_idx[c]  = wb_rd_idx;
            m_wb1_data[c] = wb_rd_data;
          end
          if (!m_held[c]) begin
            if (ex_valid && ex_stall && !e[c].stall) begin
              m_held[c] = 1;
              m_hold[c] = e[c].fwd;
            end
          end else if (!ex_stall || !ex_valid) begin
            m_held[c] = 0;
          end
          if (e[c].stall && m_cnt[c] < cnt_max[c]) m_cnt[c] = m_cnt[c] + 1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    ex_valid = 0; ex_stall = 0; rs_idx = '0; rs_used = '0; rs_data = '0;
    mem_valid = 0; mem_rd_wen = 0; mem_rd_idx = '0; mem_rd_data = '0;
    mem_is_load = 0; mem_load_done = 0;
    wb_valid = 0; wb_rd_wen = 0; wb_rd_idx = '0; wb_rd_data = '0;
  endtask

  task automatic set_src(input int i, input logic [4:0] idx, input logic used, input logic [63:0] d);
    rs_idx[5*i +: 5]   = idx;
    rs_used[i]         = used;
    rs_data[64*i +: 64] = d;
  endtask

  task automatic mem_wr(input logic [4:0] idx, input logic [63:0] d);
    mem_valid = 1; mem_rd_wen = 1; mem_rd_idx = idx; mem_rd_data = d;
  endtask

  task automatic wb_wr(input logic [4:0] idx, input logic [63:0] d);
    wb_valid = 1; wb_rd_wen = 1; wb_rd_idx = idx; wb_rd_data = d;
  endtask

  task automatic pulse_reset();
    step(); quiet(); rst = 1;
    step(); rst = 0;
  endtask

  // Watchdog so the run can never hang.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  initial begin : main
    quiet();
    rst = 1;
    step(); step();
    rst = 0;
    @(negedge clk);
    check("reset cnt0", 64'(if0.perf_lu_cnt), 64'd0);
    check("reset sel0", 64'(if0.ex_src_sel), 64'd0);

    // 1: MEM beats WB for the same register.
    step(); quiet(); ex_valid = 1;
    set_src(0, 5'd5, 1, 64'h1);
    mem_wr(5'd5, 64'hAA); wb_wr(5'd5, 64'hBB);
    @(negedge clk);
    check("t1 src0", if0.ex_src_fwd[63:0], 64'hAA);
    check("t1 sel0", 64'(if0.ex_src_sel[1:0]), 64'd1);

    // 2: x0 never forwards.
    step(); quiet(); ex_valid = 1;
    set_src(0, 5'd0, 1, 64'h1111);
    mem_wr(5'd0, 64'h55);
    @(negedge clk);
    check("t2 src0", if0.ex_src_fwd[63:0], 64'h1111);
    check("t2 sel0", 64'(if0.ex_src_sel[1:0]), 64'd0);
    check("t2 stall", 64'(if0.fwd_load_use_stall), 64'd0);

    // 3: load-use on source 1 for two cycles, then load data arrives.
    pulse_reset();
    quiet(); ex_valid = 1;
    set_src(1, 5'd7, 1, 64'h2);
    mem_wr(5'd7, 64'hDEAD); mem_is_load = 1; mem_load_done = 0;
    @(negedge clk);
    check("t3 stall c1", 64'(if0.fwd_load_use_stall), 64'd1);
    check("t3 sel1 c1", 64'(if0.ex_src_sel[3:2]), 64'd1);
    step();
    @(negedge clk);
    check("t3 stall c2", 64'(if0.fwd_load_use_stall), 64'd1);
    step(); mem_load_done = 1; mem_rd_data = 64'h1234;
    @(negedge clk);
    check("t3 stall done", 64'(if0.fwd_load_use_stall), 64'd0);
    check("t3 src1", if0.ex_src_fwd[127:64], 64'h1234);
    check("t3 cnt", 64'(if0.perf_lu_cnt), 64'd2);
    check("t3 cnt dut1", 64'(if1.perf_lu_cnt), 64'd2);

    // 4: WB+1 shadow, and its absence with a write-through regfile.
    step(); quiet();
    wb_wr(5'd9, 64'h77);
    step(); quiet(); ex_valid = 1;
    set_src(0, 5'd9, 1, 64'h5A5A);
    @(negedge clk);
    check("t4 src0", if0.ex_src_fwd[63:0], 64'h77);
    check("t4 sel0", 64'(if0.ex_src_sel[1:0]), 64'd3);
    check("t4 bypass src0", if1.ex_src_fwd[63:0], 64'h5A5A);
    check("t4 bypass sel0", 64'(if1.ex_src_sel[1:0]), 64'd0);

    // 5: capture while stalled, MEM/WB keep changing, release.
    step(); quiet(); ex_valid = 1; ex_stall = 1;
    set_src(0, 5'd3, 1, 64'h3);
    mem_wr(5'd3, 64'h10);
    @(negedge clk);
    check("t5 live src0", if0.ex_src_fwd[63:0], 64'h10);
    for (int k = 0; k < 3; k++) begin
      step();
      mem_wr(5'd3, 64'h20 + 64'(k)); wb_wr(5'd3, 64'h99);
      ex_stall = (k < 2);
      @(negedge clk);
      check($sformatf("t5 held src0 k%0d", k), if0.ex_src_fwd[63:0], 64'h10);
      check($sformatf("t5 held sel0 k%0d", k), 64'(if0.ex_src_sel[1:0]), 64'd3);
    end
    step(); quiet(); ex_valid = 1;
    set_src(0, 5'd3, 1, 64'h3);
    mem_wr(5'd3, 64'h40);
    @(negedge clk);
    check("t5 release src0", if0.ex_src_fwd[63:0], 64'h40);
    check("t5 release sel0", 64'(if0.ex_src_sel[1:0]), 64'd1);

    // 6a: reset while HELD.
    step(); quiet(); ex_valid = 1; ex_stall = 1;
    set_src(0, 5'd3, 1, 64'h3);
    mem_wr(5'd3, 64'h10);
    step();
    mem_wr(5'd3, 64'h50); rst = 1;
    @(negedge clk);
    check("t6 held before rst", 64'(if0.ex_src_sel[1:0]), 64'd3);
    step(); rst = 0;
    @(negedge clk);
    check("t6 sel after rst", 64'(if0.ex_src_sel[1:0]), 64'd1);
    check("t6 src after rst", if0.ex_src_fwd[63:0], 64'h50);
    check("t6 cnt after rst", 64'(if0.perf_lu_cnt), 64'd0);

    // 6b: counter saturation for CNT_W=2.
    pulse_reset();
    quiet(); ex_valid = 1;
    set_src(0, 5'd4, 1, 64'h4);
    mem_wr(5'd4, 64'h0); mem_is_load = 1;
    repeat (4) step();
    @(negedge clk);
    step(); quiet();
    @(negedge clk);
    check("t6 sat cnt dut1", 64'(if1.perf_lu_cnt), 64'd3);
    check("t6 cnt dut0", 64'(if0.perf_lu_cnt), 64'd5);

    // Random phase against the model.
    for (int n = 0; n < 3000; n++) begin
      step();
      rst           = ($urandom_range(0, 99) == 0);
      ex_valid      = ($urandom_range(0, 9) != 0);
      ex_stall      = ($urandom_range(0, 9) < 4);
      rs_idx        = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      rs_used       = 2'($urandom_range(0, 3));
      rs_data       = {$urandom, $urandom, $urandom, $urandom};
      mem_valid     = ($urandom_range(0, 3) != 0);
      mem_rd_wen    = ($urandom_range(0, 3) != 0);
      mem_rd_idx    = 5'($urandom_range(0, 7));
      mem_rd_data   = {$urandom, $urandom};
      mem_is_load   = ($urandom_range(0, 9) < 3);
      mem_load_done = ($urandom_range(0, 1) == 1);
      wb_valid      = ($urandom_range(0, 3) != 0);
      wb_rd_wen     = ($urandom_range(0, 3) != 0);
      wb_rd_idx     = 5'($urandom_range(0, 7));
      wb_rd_data    = {$urandom, $urandom};
    end
    step(); quiet(); rst = 0;
    @(negedge clk);
    @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
